// File: rtl/uart_pkg.sv
// Shared UART framing definitions: parser state encodings, error codes and
// default frame marker / command values.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_CMD     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [DATA_W-1:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [DATA_W-1:0] CMD_WRITE_DEF = 8'h01;
  localparam logic [DATA_W-1:0] CMD_READ_DEF  = 8'h02;

endpackage

// File: rtl/uart_byte_timeout.sv
// Loadable saturating down-counter; o_Expire is high while the count sits at
// zero. Clear has priority over load, load over decrement.
module uart_byte_timeout #(
  parameter int CNT_W = 14
) (
  input  logic             i_Clock,
  input  logic             i_Reset_n,
  input  logic             i_Clear,
  input  logic             i_Load,
  input  logic [CNT_W-1:0] i_Load_Val,
  input  logic             i_En,
  output logic             o_Expire
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      count <= '0;
    end else if (i_Clear) begin
      count <= '0;
    end else if (i_Load) begin
      count <= i_Load_Val;
    end else if (i_En && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign o_Expire = (count == '0);

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles SYNC/CMD/ADDR/DATA/CSUM frames from the UART receiver and issues
// register write / read-request strobes or coded error pulses.
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter logic [DATA_W-1:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter logic [DATA_W-1:0] CMD_WRITE    = CMD_WRITE_DEF,
  parameter logic [DATA_W-1:0] CMD_READ     = CMD_READ_DEF,
  parameter int                TIMEOUT_CLKS = 9360
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  input  logic              i_Rx_DV,
  input  logic [DATA_W-1:0] i_Rx_Byte,
  output logic              o_Wr_En,
  output logic              o_Rd_Req,
  output logic [DATA_W-1:0] o_Addr,
  output logic [DATA_W-1:0] o_Wr_Data,
  output logic              o_Err,
  output logic [1:0]        o_Err_Code,
  output logic              o_Busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT_CLKS - 1);

  state_t            state;
  logic [DATA_W-1:0] cmd_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] csum_q;
  logic              to_expire;
  logic              to_clear;
  logic              timeout_hit;

  function automatic logic is_known_cmd(input logic [DATA_W-1:0] c);
    return (c == CMD_WRITE) || (c == CMD_READ);
  endfunction

  // The counter is reloaded by every accepted byte (including SYNC, which is
  // the entry to S_CMD) and held at zero while idle.
  assign to_clear    = (state == S_IDLE) && !(i_Rx_DV && (i_Rx_Byte == SYNC_BYTE));
  assign timeout_hit = (state != S_IDLE) && to_expire && !i_Rx_DV;

  uart_byte_timeout #(
    .CNT_W (CNT_W)
  ) u_timeout (
    .i_Clock    (i_Clock),
    .i_Reset_n  (i_Reset_n),
    .i_Clear    (to_clear),
    .i_Load     (i_Rx_DV),
    .i_Load_Val (TO_LOAD),
    .i_En       (state != S_IDLE),
    .o_Expire   (to_expire)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state      <= S_IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      csum_q     <= '0;
      o_Wr_En    <= 1'b0;
      o_Rd_Req   <= 1'b0;
      o_Addr     <= '0;
      o_Wr_Data  <= '0;
      o_Err      <= 1'b0;
      o_Err_Code <= ERR_NONE;
      o_Busy     <= 1'b0;
    end else begin
      o_Wr_En  <= 1'b0;
      o_Rd_Req <= 1'b0;
      o_Err    <= 1'b0;

      if (timeout_hit) begin
        o_Err      <= 1'b1;
        o_Err_Code <= ERR_TIMEOUT;
        state      <= S_IDLE;
        o_Busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
              state  <= S_CMD;
              o_Busy <= 1'b1;
            end
          end
          S_CMD: begin
            if (i_Rx_DV) begin
              cmd_q  <= i_Rx_Byte;
              csum_q <= i_Rx_Byte;
              if (is_known_cmd(i_Rx_Byte)) begin
                state <= S_ADDR;
              end else begin
                o_Err      <= 1'b1;
                o_Err_Code <= ERR_CMD;
                state      <= S_IDLE;
                o_Busy     <= 1'b0;
              end
            end
          end
          S_ADDR: begin
            if (i_Rx_DV) begin
              addr_q <= i_Rx_Byte;
              csum_q <= csum_q ^ i_Rx_Byte;
              state  <= S_DATA;
            end
          end
          S_DATA: begin
            if (i_Rx_DV) begin
              data_q <= i_Rx_Byte;
              csum_q <= csum_q ^ i_Rx_Byte;
              state  <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (i_Rx_DV) begin
              if (i_Rx_Byte == csum_q) begin
                o_Addr    <= addr_q;
                o_Wr_Data <= data_q;
                if (cmd_q == CMD_WRITE) begin
                  o_Wr_En <= 1'b1;
                end else begin
                  o_Rd_Req <= 1'b1;
                end
              end else begin
                o_Err      <= 1'b1;
                o_Err_Code <= ERR_CSUM;
              end
              state  <= S_IDLE;
              o_Busy <= 1'b0;
            end
          end
          default: begin
            state  <= S_IDLE;
            o_Busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a frame table plus hand-written
// sequences for noise, unknown command, timeout, DV/strobe overlap and reset.
module tb_uart_cmd_parser;

  localparam int TO  = 200;
  localparam int GAP = 5;

  logic       clk;
  logic       rst_n;
  logic       dv;
  logic [7:0] rx_byte;
  logic       wr_en;
  logic       rd_req;
  logic [7:0] addr;
  logic [7:0] wr_data;
  logic       err;
  logic [1:0] err_code;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_cmd_parser #(
    .TIMEOUT_CLKS (TO)
  ) dut (
    .i_Clock    (clk),
    .i_Reset_n  (rst_n),
    .i_Rx_DV    (dv),
    .i_Rx_Byte  (rx_byte),
    .o_Wr_En    (wr_en),
    .o_Rd_Req   (rd_req),
    .o_Addr     (addr),
    .o_Wr_Data  (wr_data),
    .o_Err      (err),
    .o_Err_Code (err_code),
    .o_Busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] frame;
    logic        wr;
    logic        rd;
    logic        er;
    logic [1:0]  code;
    logic [7:0]  ad;
    logic [7:0]  wd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Returns #1 after the edge that sampled the byte.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    dv      = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    dv = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    repeat (GAP) @(posedge clk);
    send_byte(b);
  endtask

  vec_t vecs[6];

  initial begin
    int first_err;

    vecs[0] = '{40'hA5_01_10_3C_2D, 1'b1, 1'b0, 1'b0, 2'b00, 8'h10, 8'h3C};
    vecs[1] = '{40'hA5_02_22_00_20, 1'b0, 1'b1, 1'b0, 2'b00, 8'h22, 8'h00};
    vecs[2] = '{40'hA5_01_10_3C_00, 1'b0, 1'b0, 1'b1, 2'b01, 8'h22, 8'h00};
    vecs[3] = '{40'hA5_01_44_A5_E0, 1'b1, 1'b0, 1'b0, 2'b01, 8'h44, 8'hA5};
    vecs[4] = '{40'hA5_02_A5_A5_02, 1'b0, 1'b1, 1'b0, 2'b01, 8'hA5, 8'hA5};
    vecs[5] = '{40'hA5_01_FF_FF_01, 1'b1, 1'b0, 1'b0, 2'b01, 8'hFF, 8'hFF};

    rst_n   = 1'b0;
    dv      = 1'b0;
    rx_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {wr_en, rd_req, addr, wr_data, err, err_code, busy}, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      for (int j = 4; j >= 0; j--) begin
        logic [39:0] f;
        f = vecs[i].frame;
        send_gap(f[j*8 +: 8]);
        if (j == 3) chk($sformatf("v%0d_busy", i), busy, 1'b1);
      end
      chk($sformatf("v%0d_wr", i), wr_en, vecs[i].wr);
      chk($sformatf("v%0d_rd", i), rd_req, vecs[i].rd);
      chk($sformatf("v%0d_err", i), err, vecs[i].er);
      chk($sformatf("v%0d_code", i), err_code, vecs[i].code);
      chk($sformatf("v%0d_addr", i), addr, vecs[i].ad);
      chk($sformatf("v%0d_wdata", i), wr_data, vecs[i].wd);
      chk($sformatf("v%0d_busy_end", i), busy, 1'b0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pulse_end", i), {wr_en, rd_req, err}, 3'b000);
    end

    // Noise in idle, then unknown command
    send_gap(8'h55);
    send_gap(8'h00);
    chk("noise_busy", busy, 1'b0);
    chk("noise_err", err, 1'b0);
    send_gap(8'hA5);
    chk("sync_busy", busy, 1'b1);
    send_gap(8'h07);
    chk("badcmd_err", err, 1'b1);
    chk("badcmd_code", err_code, 2'b10);
    chk("badcmd_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    chk("badcmd_pulse_end", err, 1'b0);

    // Silence after CMD: error exactly TO cycles after the CMD DV
    send_gap(8'hA5);
    send_gap(8'h01);
    first_err = -1;
    for (int k = 1; k <= 2 * TO; k++) begin
      @(posedge clk);
      #1;
      if (err) begin
        first_err = k;
        break;
      end
    end
    chk("timeout_cycle", first_err, TO);
    chk("timeout_code", err_code, 2'b11);
    chk("timeout_busy", busy, 1'b0);

    // ADDR DV lands in the expiry cycle: accepted, no timeout
    send_gap(8'hA5);
    send_gap(8'h01);
    repeat (TO - 2) @(posedge clk);
    send_byte(8'h10);
    chk("expiry_dv_err", err, 1'b0);
    chk("expiry_dv_busy", busy, 1'b1);
    @(posedge clk);
    #1;
    chk("expiry_dv_err2", err, 1'b0);
    send_gap(8'h3C);
    send_gap(8'h2D);
    chk("expiry_dv_wr", wr_en, 1'b1);
    chk("expiry_dv_addr", addr, 8'h10);

    // DV in the same cycle as the strobe is checked for SYNC
    dv      = 1'b1;
    rx_byte = 8'hA5;
    @(posedge clk);
    #1;
    dv = 1'b0;
    chk("overlap_busy", busy, 1'b1);
    send_gap(8'h02);
    send_gap(8'h22);
    send_gap(8'h00);
    send_gap(8'h20);
    chk("overlap_rd", rd_req, 1'b1);
    chk("overlap_addr", addr, 8'h22);

    // Reset mid-frame
    send_gap(8'hA5);
    send_gap(8'h01);
    send_gap(8'h10);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {wr_en, rd_req, addr, wr_data, err, err_code, busy}, '0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    send_gap(8'h3C);
    chk("post_rst_3c", {wr_en, rd_req, err, busy}, 4'b0000);
    send_gap(8'h2D);
    chk("post_rst_2d", {wr_en, rd_req, err, busy}, 4'b0000);
    send_gap(8'hA5);
    send_gap(8'h01);
    send_gap(8'h10);
    send_gap(8'h3C);
    send_gap(8'h2D);
    chk("post_rst_wr", wr_en, 1'b1);
    chk("post_rst_addr", addr, 8'h10);
    chk("post_rst_wdata", wr_data, 8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
